// File: rtl/alu_multicycle_if.sv
// Bus bundle for alu_multicycle: launch handshake, operands, results and HI/LO.
// master = the controller driving start/operands, slave = the ALU.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       opcode;
  logic [5:0]       func_field;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, opcode, func_field, A, B,
    input  busy, done, result, zero, illegal, hi, lo
  );

  modport slave (
    input  start, opcode, func_field, A, B,
    output busy, done, result, zero, illegal, hi, lo
  );
endinterface

// File: rtl/alu_multicycle.sv
// alu_multicycle: MIPS-style EX-stage ALU with start/done handshake.
// Single-cycle ops finish one cycle after start; MULTU/DIVU iterate one bit
// per cycle for WIDTH cycles and write HI/LO.
// Optional feature macro ALU_SIGNED_MULDIV_EN adds signed MULT (18h) and
// DIV (1Ah); without it those funct codes decode as unsupported.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; operands captured when start is accepted
// S_EXEC | iterating multiply/divide, cnt_q counts down to zero
// S_DONE | done pulse; result/zero/illegal (and hi/lo for mul/div) valid
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  alu_multicycle_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MFHI, OP_MFLO, OP_MUL, OP_DIV, OP_ILL
  } op_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  op_t              op_dec;
  logic             sgn_dec;
  logic             op_iter;
  logic             div0;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] single_res;

  logic [WIDTH:0]     mul_add;
  logic [WIDTH+1:0]   div_trial;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  // Decode opcode/funct into an operation class and compute single-cycle results.
  always_comb begin
    op_dec  = OP_ILL;
    sgn_dec = 1'b0;
    if (bus.opcode == 6'h00) begin
      case (bus.func_field)
        6'h20:   op_dec = OP_ADD;
        6'h22:   op_dec = OP_SUB;
        6'h24:   op_dec = OP_AND;
        6'h25:   op_dec = OP_OR;
        6'h2A:   op_dec = OP_SLT;
        6'h10:   op_dec = OP_MFHI;
        6'h12:   op_dec = OP_MFLO;
        6'h19:   op_dec = OP_MUL;
        6'h1B:   op_dec = OP_DIV;
`ifdef ALU_SIGNED_MULDIV_EN
        6'h18: begin
          op_dec  = OP_MUL;
          sgn_dec = 1'b1;
        end
        6'h1A: begin
          op_dec  = OP_DIV;
          sgn_dec = 1'b1;
        end
`endif
        default: op_dec = OP_ILL;
      endcase
    end else begin
      case (bus.opcode)
        6'h23, 6'h2B: op_dec = OP_ADD;
        6'h04:        op_dec = OP_SUB;
        default:      op_dec = OP_ILL;
      endcase
    end

    op_iter = (op_dec == OP_MUL) || (op_dec == OP_DIV);
    div0    = (op_dec == OP_DIV) && (bus.B == '0);
    // Signed ops iterate on magnitudes; the most negative value maps to itself,
    // which is still the correct unsigned magnitude.
    a_mag   = (sgn_dec && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag   = (sgn_dec && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    case (op_dec)
      OP_ADD:  single_res = bus.A + bus.B;
      OP_SUB:  single_res = bus.A - bus.B;
      OP_AND:  single_res = bus.A & bus.B;
      OP_OR:   single_res = bus.A | bus.B;
      OP_SLT:  single_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_MFHI: single_res = hi_q;
      OP_MFLO: single_res = lo_q;
      default: single_res = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = (op_iter && !div0) ? S_EXEC : S_DONE;
      S_EXEC:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, one shift-add / restoring-divide step per EXEC cycle, commit.
  always_comb begin
    cnt_d     = cnt_q;
    opb_d     = opb_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    // Multiply: acc_lo holds the remaining multiplier, acc_hi the partial sum.
    mul_add   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, opb_q}) : {1'b0, acc_hi_q};
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    div_trial = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1]} - {2'b00, opb_q};

    if (is_div_q) begin
      if (div_trial[WIDTH+1]) begin
        step_hi = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end else begin
        step_hi = div_trial[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      step_hi = mul_add[WIDTH:1];
      step_lo = {mul_add[0], acc_lo_q[WIDTH-1:1]};
    end

    prod = {step_hi, step_lo};
    if (neg_quo_q) prod = -prod;
    quo    = neg_quo_q ? -step_lo : step_lo;
    rem    = neg_rem_q ? -step_hi : step_hi;
    fin_hi = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
    fin_lo = is_div_q ? quo : prod[WIDTH-1:0];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (op_iter && !div0) begin
            cnt_d     = CW'(WIDTH - 1);
            acc_hi_d  = '0;
            is_div_d  = (op_dec == OP_DIV);
            neg_quo_d = sgn_dec & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_rem_d = sgn_dec & bus.A[WIDTH-1];
            if (op_dec == OP_DIV) begin
              opb_d    = b_mag;
              acc_lo_d = a_mag;
            end else begin
              opb_d    = a_mag;
              acc_lo_d = b_mag;
            end
          end else if (div0) begin
            hi_d      = bus.A;
            lo_d      = '1;
            result_d  = '1;
            zero_d    = 1'b0;
            illegal_d = 1'b0;
          end else begin
            result_d  = single_res;
            zero_d    = (single_res == '0);
            illegal_d = (op_dec == OP_ILL);
          end
        end
      end
      S_EXEC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          hi_d      = fin_hi;
          lo_d      = fin_lo;
          result_d  = fin_lo;
          zero_d    = (fin_lo == '0);
          illegal_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State register; reset overrides any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath and architectural registers; reset also clears HI/LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      opb_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      opb_q     <= opb_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Outputs: handshake from state, data straight from registers.
  always_comb begin
    bus.busy    = (state_q != S_IDLE);
    bus.done    = (state_q == S_DONE);
    bus.result  = result_q;
    bus.zero    = zero_q;
    bus.illegal = illegal_q;
    bus.hi      = hi_q;
    bus.lo      = lo_q;
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32): directed cases, handshake
// corner cases and randomized ops against an arithmetic reference model.
module tb_alu_multicycle;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(W)) bus ();
  alu_multicycle #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected result/illegal/latency, updates model HI/LO.
  function automatic void model(input logic [5:0] opc, input logic [5:0] fn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic ill, output int lat);
    logic [63:0] p;
    longint      sq, sr;
    res = '0; ill = 1'b0; lat = 1;
    if (opc == 6'h00) begin
      case (fn)
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
        6'h10: res = m_hi;
        6'h12: res = m_lo;
        6'h19: begin
          p = {32'b0, a} * {32'b0, b};
          m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; lat = W + 1;
        end
        6'h1B: begin
          if (b == 0) begin m_lo = '1; m_hi = a; end
          else begin m_lo = a / b; m_hi = a % b; lat = W + 1; end
          res = m_lo;
        end
`ifdef ALU_SIGNED_MULDIV_EN
        6'h18: begin
          sq = longint'($signed(a)) * longint'($signed(b));
          m_hi = sq[63:32]; m_lo = sq[31:0]; res = m_lo; lat = W + 1;
        end
        6'h1A: begin
          if (b == 0) begin m_lo = '1; m_hi = a; end
          else begin
            sq = longint'($signed(a)) / longint'($signed(b));
            sr = longint'($signed(a)) % longint'($signed(b));
            m_lo = sq[31:0]; m_hi = sr[31:0]; lat = W + 1;
          end
          res = m_lo;
        end
`endif
        default: ill = 1'b1;
      endcase
    end else begin
      case (opc)
        6'h23, 6'h2B: res = a + b;
        6'h04:        res = a - b;
        default:      ill = 1'b1;
      endcase
    end
  endfunction

  // Launch one op and check the done/busy timeline and results against the model.
  task automatic run_op(input logic [5:0] opc, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] er;
    logic         ei;
    int           lat;
    model(opc, fn, a, b, er, ei, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = opc; bus.func_field = fn; bus.A = a; bus.B = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      chk({tag, "_done"}, bus.done, (k == lat));
      chk({tag, "_busy"}, bus.busy, (k <= lat));
      if (k == lat) begin
        chk({tag, "_result"},  bus.result,  er);
        chk({tag, "_zero"},    bus.zero,    (er == 0));
        chk({tag, "_illegal"}, bus.illegal, ei);
        chk({tag, "_hi"},      bus.hi,      m_hi);
        chk({tag, "_lo"},      bus.lo,      m_lo);
      end
    end
  endtask

  logic [11:0] ops [14] = '{
    {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h2A},
    {6'h00, 6'h10}, {6'h00, 6'h12}, {6'h00, 6'h19}, {6'h00, 6'h1B}, {6'h00, 6'h18},
    {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h00, 6'h3F}
  };

  initial begin
    logic [W-1:0] er;
    logic         ei;
    int           lat;
    int           ndone;
    int           dcyc;
    logic [11:0]  o;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    bus.start = 1'b0; bus.opcode = '0; bus.func_field = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",    bus.busy,    0);
    chk("rst_done",    bus.done,    0);
    chk("rst_result",  bus.result,  0);
    chk("rst_zero",    bus.zero,    0);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_hi",      bus.hi,      0);
    chk("rst_lo",      bus.lo,      0);

    run_op(6'h00, 6'h20, 32'h2222, 32'h1111, "add");
    run_op(6'h00, 6'h24, 32'h2222, 32'h1111, "and");
    run_op(6'h04, 6'h00, 32'h5555, 32'h5555, "beq");
    run_op(6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h1, "slt");
    run_op(6'h00, 6'h2A, 32'h1, 32'hFFFF_FFFF, "slt_rev");
    run_op(6'h00, 6'h19, 32'hFFFF_FFFF, 32'h2, "multu");
    run_op(6'h00, 6'h10, 32'h0, 32'h0, "mfhi");
    run_op(6'h00, 6'h12, 32'h0, 32'h0, "mflo");
    run_op(6'h00, 6'h1B, 32'd100, 32'd7, "divu");
    run_op(6'h00, 6'h1B, 32'd9, 32'd0, "divu_b0");
    run_op(6'h00, 6'h22, 32'h0, 32'h1, "sub_wrap");
    run_op(6'h00, 6'h20, 32'hFFFF_FFFF, 32'h1, "add_wrap");
    run_op(6'h23, 6'h00, 32'h1000, 32'h24, "lw");
    run_op(6'h2B, 6'h00, 32'h2000, 32'h8, "sw");
    run_op(6'h00, 6'h25, 32'hF0F0_0000, 32'h0000_0F0F, "or");
    run_op(6'h00, 6'h3F, 32'h1, 32'h2, "ill_3f");
    run_op(6'h08, 6'h00, 32'h1, 32'h2, "ill_opc");
    run_op(6'h00, 6'h18, 32'hFFFF_FFFE, 32'h3, "f18");
    run_op(6'h00, 6'h1B, 32'hFFFF_FFFF, 32'h1, "divu_by1");
    run_op(6'h00, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");

    // Extra start pulses during EXEC and DONE must be ignored.
    model(6'h00, 6'h19, 32'h1234_5678, 32'h9ABC_DEF0, er, ei, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 6'h00; bus.func_field = 6'h19;
    bus.A = 32'h1234_5678; bus.B = 32'h9ABC_DEF0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ndone = 0; dcyc = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin ndone++; dcyc = k; end
      bus.start = (k == 5 || k == 33);
      bus.A = $urandom; bus.B = $urandom;
      @(posedge clk);
      #1;
    end
    bus.start = 1'b0;
    chk("xs_ndone", ndone, 1);
    chk("xs_cycle", dcyc, 33);
    chk("xs_hi", bus.hi, m_hi);
    chk("xs_lo", bus.lo, m_lo);
    chk("xs_result", bus.result, er);

    // Reset in the middle of EXEC aborts the op and clears HI/LO.
    @(negedge clk);
    bus.start = 1'b1; bus.opcode = 6'h00; bus.func_field = 6'h19;
    bus.A = 32'hDEAD_BEEF; bus.B = 32'h7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk("ab_busy_exec", bus.busy, 1);
      chk("ab_done_exec", bus.done, 0);
      if (k == 10) rst = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_hi = '0; m_lo = '0;
    ndone = 0;
    @(negedge clk);
    chk("ab_busy", bus.busy, 0);
    chk("ab_hi", bus.hi, 0);
    chk("ab_lo", bus.lo, 0);
    chk("ab_result", bus.result, 0);
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) ndone++;
      @(negedge clk);
    end
    chk("ab_no_done", ndone, 0);

    // Reset and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.opcode = 6'h00; bus.func_field = 6'h20;
    bus.A = 32'h5; bus.B = 32'h6;
    @(posedge clk);
    #1 begin rst = 1'b0; bus.start = 1'b0; end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("rs_done", bus.done, 0);
      chk("rs_busy", bus.busy, 0);
      chk("rs_result", bus.result, 0);
    end

    // Randomized ops.
    for (int n = 0; n < 60; n++) begin
      o  = ops[$urandom_range(0, 13)];
      ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3))  : 32'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      run_op(o[11:6], o[5:0], ra, rb, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
